control_unit_seq: RTL and testbench

//  ID-stage control unit with registered outputs. Decodes {mode, opCode, s}

---
 rtl/control_unit_seq.sv | 208 ++++++++++++++++++++
 tb/tb_control_unit_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq.sv
// ID-stage control unit: decodes {mode, opCode, s} into a registered ID/EX bundle
// and sequences multi-cycle MEM (ready/timeout) and MUL (fixed latency) ops.
module control_unit_seq #(
  parameter int CMD_W       = 4,
  parameter int ENABLE_MUL  = 1,
  parameter int MUL_LATENCY = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [1:0]       mode,
  input  logic [3:0]       opCode,
  input  logic             s,
  input  logic             hazard,
  input  logic             flush,
  input  logic             mem_ready,
  output logic             WB_EN,
  output logic             MEM_R_EN,
  output logic             MEM_W_EN,
  output logic             B,
  output logic             S,
  output logic [CMD_W-1:0] EXE_CMD,
  output logic             out_valid,
  output logic             freeze,
  output logic             illegal,
  output logic             mem_err
);

  // state       | meaning
  // ST_DECODE   | accepting instructions, bundle reloads every edge
  // ST_MEM_WAIT | memory access outstanding, bundle held until ready/timeout
  // ST_MUL_BUSY | multiply occupying the stage, bundle held until count expires
  typedef enum logic [1:0] {ST_DECODE, ST_MEM_WAIT, ST_MUL_BUSY} state_t;

  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int MCNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                wb_q, wb_d, mr_q, mr_d, mw_q, mw_d, b_q, b_d, s_q, s_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic                ov_q, ov_d, ill_q, ill_d, merr_q, merr_d;

  logic                dec_ok, dec_wb, dec_mr, dec_mw, dec_b, dec_s, dec_mem, dec_mul;
  logic [3:0]          dec_cmd;

  always_comb begin
    dec_ok  = 1'b1;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_mem = 1'b0;
    dec_mul = 1'b0;
    dec_cmd = 4'd0;
    case (mode)
      2'd0: begin
        dec_wb = 1'b1;
        dec_s  = s;
        case (opCode)
          4'd13:   dec_cmd = 4'd1;
          4'd15:   dec_cmd = 4'd9;
          4'd4:    dec_cmd = 4'd2;
          4'd5:    dec_cmd = 4'd3;
          4'd2:    dec_cmd = 4'd4;
          4'd6:    dec_cmd = 4'd5;
          4'd0:    dec_cmd = 4'd6;
          4'd12:   dec_cmd = 4'd7;
          4'd1:    dec_cmd = 4'd8;
          4'd10:   begin dec_cmd = 4'd4; dec_wb = 1'b0; dec_s = 1'b1; end
          4'd8:    begin dec_cmd = 4'd6; dec_wb = 1'b0; dec_s = 1'b1; end
          default: dec_ok = 1'b0;
        endcase
      end
      2'd1: begin
        dec_mem = 1'b1;
        dec_cmd = 4'd2;
        dec_s   = s;
        dec_mr  = s;
        dec_wb  = s;
        dec_mw  = ~s;
      end
      2'd2: dec_b = 1'b1;
      default: begin
        if (ENABLE_MUL != 0) begin
          dec_mul = 1'b1;
          dec_cmd = 4'd10;
          dec_wb  = 1'b1;
          dec_s   = s;
        end else begin
          dec_ok = 1'b0;
        end
      end
    endcase
  end

  assign wcnt_inc = wcnt_q + WCNT_W'(1);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    mcnt_d  = mcnt_q;
    wb_d    = wb_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    b_d     = b_q;
    s_d     = s_q;
    cmd_d   = cmd_q;
    ov_d    = ov_q;
    ill_d   = 1'b0;
    merr_d  = 1'b0;
    if (flush || state_q == ST_DECODE ||
        (state_q == ST_MEM_WAIT && (mem_ready || wcnt_inc == WCNT_W'(MEM_TIMEOUT)))) begin
      // Every path that leaves or sits in DECODE starts from a bubble.
      {wb_d, mr_d, mw_d, b_d, s_d, ov_d} = '0;
      cmd_d = '0;
    end
    if (flush) begin
      state_d = ST_DECODE;
      wcnt_d  = '0;
      mcnt_d  = '0;
    end else begin
      case (state_q)
        ST_DECODE: begin
          if (instr_valid && !hazard) begin
            if (dec_ok) begin
              {wb_d, mr_d, mw_d, b_d, s_d} = {dec_wb, dec_mr, dec_mw, dec_b, dec_s};
              cmd_d = CMD_W'(dec_cmd);
              ov_d  = 1'b1;
              if (dec_mem) begin
                state_d = ST_MEM_WAIT;
                wcnt_d  = '0;
              end
              if (dec_mul && MUL_LATENCY > 1) begin
                state_d = ST_MUL_BUSY;
                mcnt_d  = MCNT_W'(MUL_LATENCY - 2);
              end
            end else begin
              ill_d = 1'b1;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state_d = ST_DECODE;
            wcnt_d  = '0;
          end else if (wcnt_inc == WCNT_W'(MEM_TIMEOUT)) begin
            state_d = ST_DECODE;
            wcnt_d  = '0;
            merr_d  = 1'b1;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        ST_MUL_BUSY: begin
          if (mcnt_q == '0) state_d = ST_DECODE;
          else              mcnt_d  = mcnt_q - MCNT_W'(1);
        end
        default: state_d = ST_DECODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_DECODE;
      wcnt_q  <= '0;
      mcnt_q  <= '0;
      wb_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      b_q     <= 1'b0;
      s_q     <= 1'b0;
      cmd_q   <= '0;
      ov_q    <= 1'b0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      mcnt_q  <= mcnt_d;
      wb_q    <= wb_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cmd_q   <= cmd_d;
      ov_q    <= ov_d;
      ill_q   <= ill_d;
      merr_q  <= merr_d;
    end
  end

  assign WB_EN     = wb_q;
  assign MEM_R_EN  = mr_q;
  assign MEM_W_EN  = mw_q;
  assign B         = b_q;
  assign S         = s_q;
  assign EXE_CMD   = cmd_q;
  assign out_valid = ov_q;
  assign illegal   = ill_q;
  assign mem_err   = merr_q;
  assign freeze    = (state_q != ST_DECODE);

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed bench for control_unit_seq: default instance plus an ENABLE_MUL=0 instance
// sharing stimulus; bundle packed as {out_valid,WB_EN,MEM_R_EN,MEM_W_EN,B,S,EXE_CMD}.
module tb_control_unit_seq;
  logic clk = 1'b0;
  logic rst_n, instr_valid, s, hazard, flush, mem_ready;
  logic [1:0] mode;
  logic [3:0] opCode;

  logic wb, mr, mw, b, sf, ov, frz, ill, merr;
  logic [3:0] cmd;
  logic wb2, mr2, mw2, b2, sf2, ov2, frz2, ill2, merr2;
  logic [3:0] cmd2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  control_unit_seq u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .mode(mode), .opCode(opCode),
    .s(s), .hazard(hazard), .flush(flush), .mem_ready(mem_ready),
    .WB_EN(wb), .MEM_R_EN(mr), .MEM_W_EN(mw), .B(b), .S(sf), .EXE_CMD(cmd),
    .out_valid(ov), .freeze(frz), .illegal(ill), .mem_err(merr)
  );

  control_unit_seq #(.ENABLE_MUL(0)) u_dut_nomul (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .mode(mode), .opCode(opCode),
    .s(s), .hazard(hazard), .flush(flush), .mem_ready(mem_ready),
    .WB_EN(wb2), .MEM_R_EN(mr2), .MEM_W_EN(mw2), .B(b2), .S(sf2), .EXE_CMD(cmd2),
    .out_valid(ov2), .freeze(frz2), .illegal(ill2), .mem_err(merr2)
  );

  wire [9:0] bundle  = {ov, wb, mr, mw, b, sf, cmd};
  wire [9:0] bundle2 = {ov2, wb2, mr2, mw2, b2, sf2, cmd2};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] mk(input logic v, input logic w, input logic r,
                                    input logic m, input logic br, input logic sb,
                                    input logic [3:0] c);
    return {v, w, r, m, br, sb, c};
  endfunction

  // ARITH reference table: returns expected bundle, illegal flag in bit 10
  function automatic logic [10:0] arith_exp(input logic [3:0] op, input logic sb);
    case (op)
      4'd13: return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd1)};
      4'd15: return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd9)};
      4'd4:  return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd2)};
      4'd5:  return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd3)};
      4'd2:  return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd4)};
      4'd6:  return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd5)};
      4'd0:  return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd6)};
      4'd12: return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd7)};
      4'd1:  return {1'b0, mk(1, 1, 0, 0, 0, sb, 4'd8)};
      4'd10: return {1'b0, mk(1, 0, 0, 0, 0, 1'b1, 4'd4)};
      4'd8:  return {1'b0, mk(1, 0, 0, 0, 0, 1'b1, 4'd6)};
      default: return {1'b1, 10'd0};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] md, input logic [3:0] op, input logic sb);
    instr_valid = 1'b1; mode = md; opCode = op; s = sb;
  endtask

  logic [10:0] e;
  logic [9:0]  ldr_b, str_b, mul_b;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; mode = 2'd0; opCode = 4'd0; s = 1'b0;
    hazard = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    ldr_b = mk(1, 1, 1, 0, 0, 1, 4'd2);
    str_b = mk(1, 0, 0, 1, 0, 0, 4'd2);
    mul_b = mk(1, 1, 0, 0, 0, 1, 4'd10);
    step(); step();
    check("reset bundle", bundle, 0);
    check("reset flags", {frz, ill, merr}, 0);
    rst_n = 1'b1;

    // ARITH sweep, back-to-back in DECODE
    for (int op = 0; op < 16; op++) begin
      for (int sv = 0; sv < 2; sv++) begin
        issue(2'd0, 4'(op), 1'(sv));
        step();
        e = arith_exp(4'(op), 1'(sv));
        check($sformatf("arith op%0d s%0d bundle", op, sv), bundle, e[9:0]);
        check($sformatf("arith op%0d s%0d illegal", op, sv), ill, e[10]);
        check($sformatf("arith op%0d s%0d freeze", op, sv), frz, 0);
      end
    end
    instr_valid = 1'b0;
    step();
    check("idle bubble", bundle, 0);
    check("illegal pulse ends", ill, 0);

    issue(2'd0, 4'd4, 1'b1); hazard = 1'b1;
    step();
    check("hazard bubble", bundle, 0);
    hazard = 1'b0;
    issue(2'd2, 4'd7, 1'b1);
    step();
    check("branch", bundle, mk(1, 0, 0, 0, 1, 0, 4'd0));

    // LDR: three edges without ready, ready on the fourth
    issue(2'd1, 4'd0, 1'b1);
    step();
    check("ldr latch", bundle, ldr_b);
    check("ldr freeze", frz, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ldr hold %0d", i), bundle, ldr_b);
      check($sformatf("ldr freeze %0d", i), frz, 1);
    end
    instr_valid = 1'b0; mem_ready = 1'b1;
    step();
    check("ldr done bundle", bundle, 0);
    check("ldr done flags", {frz, merr}, 0);
    step();
    check("ready ignored in decode", {bundle, frz}, 0);
    mem_ready = 1'b0;

    // STR timeout
    issue(2'd1, 4'd0, 1'b0);
    step();
    check("str latch", bundle, str_b);
    instr_valid = 1'b0;
    for (int i = 1; i < 15; i++) begin
      step();
      check($sformatf("str wait %0d", i), {bundle, frz, merr}, {str_b, 2'b10});
    end
    step();
    check("str timeout", {bundle, frz, merr}, {10'd0, 2'b01});
    step();
    check("mem_err pulse ends", merr, 0);

    // STR with ready on the timeout edge
    issue(2'd1, 4'd0, 1'b0);
    step();
    instr_valid = 1'b0;
    for (int i = 1; i < 15; i++) step();
    check("str2 still waiting", {bundle, frz}, {str_b, 1'b1});
    mem_ready = 1'b1;
    step();
    check("ready beats timeout", {bundle, frz, merr}, 0);
    mem_ready = 1'b0;

    // MUL: held 3 cycles, freeze 2
    issue(2'd3, 4'd5, 1'b1);
    step();
    check("mul latch", {bundle, frz}, {mul_b, 1'b1});
    check("nomul illegal", {bundle2, ill2}, {10'd0, 1'b1});
    instr_valid = 1'b0;
    step();
    check("mul hold 1", {bundle, frz}, {mul_b, 1'b1});
    step();
    check("mul hold 2", {bundle, frz}, {mul_b, 1'b0});
    step();
    check("mul done", {bundle, frz}, 0);

    // flush in MUL_BUSY and MEM_WAIT, and in DECODE
    issue(2'd3, 4'd0, 1'b0);
    step();
    instr_valid = 1'b0; flush = 1'b1;
    step();
    check("flush mul", {bundle, frz}, 0);
    flush = 1'b0;
    issue(2'd1, 4'd0, 1'b1);
    step();
    instr_valid = 1'b0;
    step();
    flush = 1'b1; mem_ready = 1'b1;
    step();
    check("flush mem", {bundle, frz, merr}, 0);
    mem_ready = 1'b0;
    issue(2'd0, 4'd4, 1'b0);
    step();
    check("flush kills decode", bundle, 0);
    flush = 1'b0;
    step();
    check("after flush add", bundle, mk(1, 1, 0, 0, 0, 0, 4'd2));

    // reset in the middle of MEM_WAIT
    issue(2'd1, 4'd0, 1'b1);
    step();
    instr_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step(); step();
    check("reset mid mem", {bundle, frz, ill, merr}, 0);
    rst_n = 1'b1;
    issue(2'd0, 4'd1, 1'b1);
    step();
    check("post reset eor", bundle, mk(1, 1, 0, 0, 0, 1, 4'd8));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
